// File: rtl/fir_sched_pkg.sv
// Shared types and widths for the FIR job scheduler.
//   COEF_W / DATA_W : widths of the coefficient count and sample count of a job
//   LVL_W           : width of the queue occupancy count (holds 0..16)
//   CNT_W           : width of the completed-job counter
//   state_t         : scheduler FSM states
//   job_t           : one queued job {ile_wsp, ile_probek}
package fir_sched_pkg;

  localparam int COEF_W = 6;
  localparam int DATA_W = 14;
  localparam int LVL_W  = 5;
  localparam int CNT_W  = 8;

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    LAUNCH   = 3'd1,
    WAIT_ACK = 3'd2,
    RUN      = 3'd3,
    FINISH   = 3'd4
  } state_t;

  typedef struct packed {
    logic [COEF_W-1:0] ile_wsp;
    logic [DATA_W-1:0] ile_probek;
  } job_t;

endpackage

// File: rtl/fir_job_fifo.sv
// Synchronous job FIFO for the FIR scheduler.
// Ports:
//   clk, rst      : clock, asynchronous active-high reset (control state only)
//   push, din     : write one job when not full and not flushing
//   pop, dout     : dout always shows the head entry; pop advances it
//   flush         : empties the queue this cycle, overriding push and pop
//   level         : number of stored jobs
//   full, empty   : derived from the registered level
module fir_job_fifo
  import fir_sched_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic             pop,
  input  logic             flush,
  input  job_t             din,
  output job_t             dout,
  output logic [LVL_W-1:0] level,
  output logic             full,
  output logic             empty
);

  localparam int AW = $clog2(DEPTH);

  job_t             mem [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [LVL_W-1:0] level_q, level_d;
  logic             do_push, do_pop;

  assign full    = (level_q == LVL_W'(DEPTH));
  assign empty   = (level_q == '0);
  assign do_push = push && !full && !flush;
  assign do_pop  = pop && !empty && !flush;
  assign dout    = mem[rd_ptr_q];
  assign level   = level_q;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    level_d  = level_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      level_d  = '0;
    end else begin
      if (do_push) wr_ptr_d = wr_ptr_q + AW'(1);
      if (do_pop)  rd_ptr_d = rd_ptr_q + AW'(1);
      if (do_push && !do_pop)      level_d = level_q + LVL_W'(1);
      else if (!do_push && do_pop) level_d = level_q - LVL_W'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q  <= level_d;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr_q] <= din;
  end

endmodule

// File: rtl/fir_job_scheduler.sv
// FIR job scheduler: queues host jobs and launches them one at a time on a
// FIR core, tracking completions and error conditions.
// Ports:
//   clk, rst                          : clock, asynchronous active-high reset
//   job_valid/job_ready, job_ile_*    : host job offer handshake
//   flush                             : drop all queued (not running) jobs
//   clr_err                           : clear sticky error flags
//   f_start, f_ile_*, f_pracuje,
//   f_done, f_abort                   : FIR core control
//   busy, queue_level, jobs_done_cnt  : status
//   irq_done                          : one pulse per completed job
//   err_bad_job, err_timeout          : sticky error flags
// Optional feature macro FIR_SCHED_TIMEOUT_EN: adds a watchdog over the
// WAIT_ACK+RUN time that aborts the job after TIMEOUT_CYC cycles. Without it
// f_abort and err_timeout are constant 0.
module fir_job_scheduler
  import fir_sched_pkg::*;
#(
  parameter int DEPTH       = 4,
  parameter int TIMEOUT_CYC = 65535
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              job_valid,
  output logic              job_ready,
  input  logic [COEF_W-1:0] job_ile_wsp,
  input  logic [DATA_W-1:0] job_ile_probek,
  input  logic              flush,
  input  logic              clr_err,
  output logic              f_start,
  output logic [COEF_W-1:0] f_ile_wsp,
  output logic [DATA_W-1:0] f_ile_probek,
  input  logic              f_pracuje,
  input  logic              f_done,
  output logic              f_abort,
  output logic              busy,
  output logic [LVL_W-1:0]  queue_level,
  output logic [CNT_W-1:0]  jobs_done_cnt,
  output logic              irq_done,
  output logic              err_bad_job,
  output logic              err_timeout
);

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (v == {CNT_W{1'b1}}) ? v : v + CNT_W'(1);
  endfunction

  state_t            state_q, state_d;
  logic [COEF_W-1:0] wsp_q, wsp_d;
  logic [DATA_W-1:0] probek_q, probek_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              err_bad_q, err_bad_d;
  logic              accept, bad_job, fifo_push, fifo_pop;
  logic              fifo_full, fifo_empty;
  job_t              fifo_din, fifo_head;
  logic              abort;

  // Ready is gated by reset so nothing is offered while the block is held.
  assign job_ready = !fifo_full && !flush && !rst;
  assign accept    = job_valid && job_ready;
  assign bad_job   = accept && ((job_ile_wsp == '0) || (job_ile_probek == '0));
  assign fifo_push = accept && !bad_job;
  assign fifo_din  = '{ile_wsp: job_ile_wsp, ile_probek: job_ile_probek};

  fir_job_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (fifo_push),
    .pop   (fifo_pop),
    .flush (flush),
    .din   (fifo_din),
    .dout  (fifo_head),
    .level (queue_level),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

`ifdef FIR_SCHED_TIMEOUT_EN
  localparam int WD_W = $clog2(TIMEOUT_CYC + 1);
  logic [WD_W-1:0] wd_q, wd_d;
  logic            err_to_q, err_to_d;
`endif

  always_comb begin
    state_d  = state_q;
    wsp_d    = wsp_q;
    probek_d = probek_q;
    cnt_d    = cnt_q;
    fifo_pop = 1'b0;
    f_start  = 1'b0;
    irq_done = 1'b0;
    abort    = 1'b0;
    case (state_q)
      IDLE: begin
        // A flush in the same cycle discards the head too.
        if (!fifo_empty && !flush) begin
          fifo_pop = 1'b1;
          wsp_d    = fifo_head.ile_wsp;
          probek_d = fifo_head.ile_probek;
          state_d  = LAUNCH;
        end
      end
      LAUNCH: begin
        f_start = 1'b1;
        state_d = WAIT_ACK;
      end
      WAIT_ACK: begin
        if (f_done)         state_d = FINISH;
        else if (f_pracuje) state_d = RUN;
      end
      RUN: begin
        if (f_done) state_d = FINISH;
      end
      FINISH: begin
        irq_done = 1'b1;
        cnt_d    = sat_inc(cnt_q);
        state_d  = IDLE;
      end
      default: state_d = IDLE;
    endcase
`ifdef FIR_SCHED_TIMEOUT_EN
    wd_d = wd_q;
    // f_done in the last watchdog cycle still completes the job normally.
    if (state_q == LAUNCH) begin
      wd_d = '0;
    end else if ((state_q == WAIT_ACK || state_q == RUN) && !f_done) begin
      if (wd_q == WD_W'(TIMEOUT_CYC - 1)) begin
        abort   = 1'b1;
        state_d = IDLE;
      end else begin
        wd_d = wd_q + WD_W'(1);
      end
    end
    err_to_d = abort || (err_to_q && !clr_err);
`endif
    err_bad_d = bad_job || (err_bad_q && !clr_err);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      wsp_q     <= '0;
      probek_q  <= '0;
      cnt_q     <= '0;
      err_bad_q <= 1'b0;
`ifdef FIR_SCHED_TIMEOUT_EN
      wd_q      <= '0;
      err_to_q  <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      wsp_q     <= wsp_d;
      probek_q  <= probek_d;
      cnt_q     <= cnt_d;
      err_bad_q <= err_bad_d;
`ifdef FIR_SCHED_TIMEOUT_EN
      wd_q      <= wd_d;
      err_to_q  <= err_to_d;
`endif
    end
  end

  assign f_ile_wsp     = wsp_q;
  assign f_ile_probek  = probek_q;
  assign busy          = (state_q != IDLE);
  assign jobs_done_cnt = cnt_q;
  assign err_bad_job   = err_bad_q;
`ifdef FIR_SCHED_TIMEOUT_EN
  assign f_abort       = abort;
  assign err_timeout   = err_to_q;
`else
  assign f_abort       = 1'b0;
  assign err_timeout   = 1'b0;
`endif

endmodule

// File: tb/tb_fir_job_scheduler.sv
// Testbench for fir_job_scheduler: directed job sequences, a job-lifecycle
// reference model checked on every cycle, and literal spot checks.
`timescale 1ns/1ps
module tb_fir_job_scheduler;

  localparam int DEPTH  = 4;
  localparam int TO_CYC = 16;
`ifdef FIR_SCHED_TIMEOUT_EN
  localparam bit TO_EN = 1'b1;
`else
  localparam bit TO_EN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        job_valid = 1'b0;
  logic [5:0]  job_ile_wsp = '0;
  logic [13:0] job_ile_probek = '0;
  logic        flush = 1'b0;
  logic        clr_err = 1'b0;
  logic        f_pracuje = 1'b0;
  logic        f_done = 1'b0;
  logic        job_ready, f_start, f_abort, busy, irq_done, err_bad_job, err_timeout;
  logic [5:0]  f_ile_wsp;
  logic [13:0] f_ile_probek;
  logic [4:0]  queue_level;
  logic [7:0]  jobs_done_cnt;

  fir_job_scheduler #(.DEPTH(DEPTH), .TIMEOUT_CYC(TO_CYC)) dut (
    .clk(clk), .rst(rst), .job_valid(job_valid), .job_ready(job_ready),
    .job_ile_wsp(job_ile_wsp), .job_ile_probek(job_ile_probek),
    .flush(flush), .clr_err(clr_err), .f_start(f_start),
    .f_ile_wsp(f_ile_wsp), .f_ile_probek(f_ile_probek),
    .f_pracuje(f_pracuje), .f_done(f_done), .f_abort(f_abort),
    .busy(busy), .queue_level(queue_level), .jobs_done_cnt(jobs_done_cnt),
    .irq_done(irq_done), .err_bad_job(err_bad_job), .err_timeout(err_timeout)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_bad = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, required %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model (job lifecycle) ----------------
  logic [19:0] mq[$];
  bit          m_act = 1'b0;   // a job has left the queue and not yet retired
  int          m_age = 0;      // 1 in the launch cycle, >=2 while waiting on the core
  bit          m_done = 1'b0;  // core reported done; retire cycle is now
  int          m_wait = 0;     // cycles spent waiting on the core without done
  logic [5:0]  m_wsp = '0;
  logic [13:0] m_probek = '0;
  int          m_cnt = 0;
  bit          m_err_bad = 1'b0;
  bit          m_err_to = 1'b0;

  function automatic bit m_ready();
    return !rst && (mq.size() < DEPTH) && !flush;
  endfunction

  function automatic bit m_abort();
    return TO_EN && m_act && (m_age >= 2) && !m_done && !f_done && (m_wait == TO_CYC - 1);
  endfunction

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      mq.delete();
      m_act = 1'b0; m_age = 0; m_done = 1'b0; m_wait = 0;
      m_wsp = '0; m_probek = '0; m_cnt = 0; m_err_bad = 1'b0; m_err_to = 1'b0;
    end else begin
      bit was_idle, acc, ab, set_bad;
      was_idle = !m_act;
      acc      = job_valid && m_ready();
      ab       = m_abort();
      set_bad  = acc && (job_ile_wsp == 0 || job_ile_probek == 0);
      if (m_act) begin
        if (m_done) begin
          m_act = 1'b0;
          if (m_cnt < 255) m_cnt++;
        end else if (ab) begin
          m_act = 1'b0;
        end else begin
          if (m_age >= 2) begin
            if (f_done) m_done = 1'b1;
            else        m_wait++;
          end
          m_age++;
        end
      end
      if (flush) begin
        mq.delete();
      end else begin
        if (was_idle && mq.size() > 0) begin
          {m_wsp, m_probek} = mq.pop_front();
          m_act = 1'b1; m_age = 1; m_done = 1'b0; m_wait = 0;
        end
        if (acc && !set_bad) mq.push_back({job_ile_wsp, job_ile_probek});
      end
      m_err_bad = set_bad || (m_err_bad && !clr_err);
      m_err_to  = ab || (m_err_to && !clr_err);
    end
  end

  always @(negedge clk) begin
    chk("job_ready",     job_ready,     m_ready());
    chk("f_start",       f_start,       m_act && m_age == 1);
    chk("f_ile_wsp",     f_ile_wsp,     m_wsp);
    chk("f_ile_probek",  f_ile_probek,  m_probek);
    chk("f_abort",       f_abort,       m_abort());
    chk("busy",          busy,          m_act);
    chk("queue_level",   queue_level,   mq.size());
    chk("jobs_done_cnt", jobs_done_cnt, m_cnt);
    chk("irq_done",      irq_done,      m_act && m_done);
    chk("err_bad_job",   err_bad_job,   m_err_bad);
    chk("err_timeout",   err_timeout,   m_err_to);
  end

  logic [19:0] started[$];
  always @(negedge clk) if (f_start === 1'b1) started.push_back({f_ile_wsp, f_ile_probek});

  // ---------------- stimulus ----------------
  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic push_job(input logic [5:0] w, input logic [13:0] p);
    int n = 0;
    #1;
    job_valid = 1'b1; job_ile_wsp = w; job_ile_probek = p;
    @(negedge clk);
    while (job_ready !== 1'b1 && n < 200) begin n++; @(negedge clk); end
    if (job_ready !== 1'b1) begin
      n_vec++; n_bad++;
      $display("FAIL push_wait: job_ready=%b, required 1 within 200 cycles", job_ready);
    end
    tick();
    job_valid = 1'b0;
  endtask

  task automatic wait_starts(input int target);
    int n = 0;
    while (started.size() < target && n < 200) begin @(negedge clk); #1; n++; end
    if (started.size() < target) begin
      n_vec++; n_bad++;
      $display("FAIL start_wait: %0d starts, required %0d", started.size(), target);
    end
  endtask

  task automatic pulse_done();
    tick(); f_done = 1'b1;
    tick(); f_done = 1'b0;
  endtask

  logic [19:0] exp_order [5];
  logic [19:0] e;

  initial begin
    #400000;
    $display("FAIL global_timeout: simulation did not finish, required finish");
    $fatal(1, "timeout");
  end

  initial begin
    // reset state
    @(negedge clk);
    chk("rst_busy", busy, 0); chk("rst_level", queue_level, 0); chk("rst_cnt", jobs_done_cnt, 0);
    chk("rst_wsp", f_ile_wsp, 0); chk("rst_ready", job_ready, 0); chk("rst_start", f_start, 0);
    @(posedge clk); #1 rst = 1'b0;
    repeat (2) tick();

    // single job: launch two cycles after the push, then completion
    started.delete();
    push_job(6'd8, 14'd100);
    @(negedge clk); chk("t1_start_pop_cycle", f_start, 0);
    @(negedge clk); chk("t1_start", f_start, 1);
    chk("t1_wsp", f_ile_wsp, 8); chk("t1_probek", f_ile_probek, 100);
    pulse_done();
    @(negedge clk); chk("t1_irq", irq_done, 1);
    @(negedge clk); chk("t1_cnt", jobs_done_cnt, 1); chk("t1_irq_off", irq_done, 0); chk("t1_idle", busy, 0);

    // zero-length jobs are dropped
    tick();
    push_job(6'd0, 14'd5);
    @(negedge clk); chk("bad_err", err_bad_job, 1); chk("bad_level", queue_level, 0); chk("bad_busy", busy, 0);
    tick(); clr_err = 1'b1; tick(); clr_err = 1'b0;
    @(negedge clk); chk("bad_clr", err_bad_job, 0);
    tick(); clr_err = 1'b1;
    push_job(6'd3, 14'd0);
    clr_err = 1'b0;
    @(negedge clk); chk("bad_set_wins", err_bad_job, 1); chk("bad_starts", started.size(), 1);
    tick(); clr_err = 1'b1; tick(); clr_err = 1'b0;

    // five jobs with the core busy: queue fills, then FIFO order
    started.delete(); f_pracuje = 1'b1;
    for (int i = 0; i < 5; i++) begin
      exp_order[i] = {6'(i + 1), 14'(11 * (i + 1))};
      push_job(6'(i + 1), 14'(11 * (i + 1)));
    end
    @(negedge clk); chk("full_level", queue_level, 4); chk("full_ready", job_ready, 0); chk("full_busy", busy, 1);
    for (int i = 0; i < 5; i++) begin
      wait_starts(i + 1);
      pulse_done();
    end
    repeat (3) @(negedge clk);
    chk("order_count", started.size(), 5);
    for (int i = 0; i < 5; i++) begin
      e = started[i];
      chk("order_job", e, exp_order[i]);
    end
    chk("order_cnt", jobs_done_cnt, 6);

    // flush while a job runs
    tick(); started.delete();
    push_job(6'd10, 14'd200); push_job(6'd11, 14'd201); push_job(6'd12, 14'd202);
    tick(); flush = 1'b1; tick(); flush = 1'b0;
    @(negedge clk); chk("flush_level", queue_level, 0); chk("flush_busy", busy, 1);
    pulse_done();
    @(negedge clk); chk("flush_irq", irq_done, 1);
    repeat (8) @(negedge clk);
    chk("flush_idle", busy, 0); chk("flush_starts", started.size(), 1); chk("flush_cnt", jobs_done_cnt, 7);

`ifdef FIR_SCHED_TIMEOUT_EN
    // watchdog: the core never reports done
    begin
      int k;
      k = 0;
      tick();
      push_job(6'd7, 14'd77);
      while (f_start !== 1'b1 && k < 20) begin @(negedge clk); k++; end
      chk("to_started", f_start, 1);
      k = 0;
      @(negedge clk); k++;
      while (f_abort !== 1'b1 && k < 40) begin @(negedge clk); k++; end
      chk("to_cycle", k, 16);
      @(negedge clk);
      chk("to_err", err_timeout, 1); chk("to_busy", busy, 0); chk("to_cnt", jobs_done_cnt, 7); chk("to_abort_off", f_abort, 0);
      tick(); clr_err = 1'b1; tick(); clr_err = 1'b0;
      @(negedge clk); chk("to_clr", err_timeout, 0);
    end
`endif

    // reset in the middle of a running job
    tick(); started.delete();
    push_job(6'd9, 14'd90); push_job(6'd6, 14'd60); push_job(6'd5, 14'd50);
    tick();
    @(negedge clk); chk("mid_busy", busy, 1);
    #2 rst = 1'b1;
    @(negedge clk);
    chk("mid_rst_busy", busy, 0); chk("mid_rst_level", queue_level, 0); chk("mid_rst_cnt", jobs_done_cnt, 0);
    chk("mid_rst_wsp", f_ile_wsp, 0); chk("mid_rst_probek", f_ile_probek, 0); chk("mid_rst_irq", irq_done, 0);
    chk("mid_rst_abort", f_abort, 0); chk("mid_rst_ready", job_ready, 0);
    tick(); rst = 1'b0; f_pracuje = 1'b0;
    repeat (6) @(negedge clk);
    chk("post_rst_idle", busy, 0); chk("post_rst_starts", started.size(), 1);

    // completed-job counter saturates at 255
    tick(); started.delete();
    for (int i = 0; i < 257; i++) begin
      push_job(6'((i % 63) + 1), 14'(i + 1));
      wait_starts(i + 1);
      pulse_done();
    end
    repeat (3) @(negedge clk);
    chk("sat_cnt", jobs_done_cnt, 255);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
